// File: rtl/parallel_test_ctrl_if.sv
// parallel_test_ctrl_if: host/aligner/checker side of the loopback
// test sequencer, grouped as one bundle.
interface parallel_test_ctrl_if;
  logic       START;
  logic       ABORT;
  logic       ALIGNED;
  logic [7:0] ERR_CNT;
  logic       RX_CLR;
  logic       RX_INIT;
  logic       ALIGN_REQ;
  logic       TX_EN;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [2:0] FAIL_CODE;
  logic [3:0] RETRY_CNT;
  logic [7:0] LAST_ERR;

  modport master (
    output START, ABORT, ALIGNED, ERR_CNT,
    input  RX_CLR, RX_INIT, ALIGN_REQ, TX_EN,
    input  BUSY, DONE, PASS, FAIL_CODE,
    input  RETRY_CNT, LAST_ERR
  );

  modport slave (
    input  START, ABORT, ALIGNED, ERR_CNT,
    output RX_CLR, RX_INIT, ALIGN_REQ, TX_EN,
    output BUSY, DONE, PASS, FAIL_CODE,
    output RETRY_CNT, LAST_ERR
  );
endinterface

// File: rtl/parallel_test_ctrl.sv
// parallel_test_ctrl: one loopback test sequence
// (clear, align, init, run, drain, judge) with bounded retries.
module parallel_test_ctrl #(
  parameter int unsigned TEST_CYCLES   = 65536,
  parameter int unsigned ALIGN_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned ERR_THRESH    = 0
) (
  input logic                 CLK,
  input logic                 RSTX,
  parallel_test_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ALIGN, INIT,
    RUN, DRAIN, JUDGE, DONE_ST
  } state_t;

  localparam logic [23:0] ALIGN_LAST =
    24'(ALIGN_TIMEOUT - 1);
  localparam logic [23:0] RUN_LAST =
    24'(TEST_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX =
    4'(MAX_RETRY);
  localparam logic [7:0] THRESH =
    8'(ERR_THRESH);

  state_t      state;
  state_t      state_nx;
  logic [23:0] timer;

  logic        fail;
  logic [2:0]  code;
  logic        judge_ok;
  logic        cap_err;
  logic        abort_go;
  logic        start_go;
  logic        retry_ok;

  logic        rx_clr_nx, rx_init_nx;
  logic        align_req_nx, tx_en_nx;
  logic        busy_nx, done_nx;

  logic        rx_clr_q, rx_init_q;
  logic        align_req_q, tx_en_q;
  logic        busy_q, done_q;
  logic        pass_q;
  logic [2:0]  fail_code_q;
  logic [3:0]  retry_q;
  logic [7:0]  last_err_q;

  assign abort_go = bus.ABORT &&
                    (state != IDLE);
  assign start_go = (state == IDLE) &&
                    bus.START && !bus.ABORT;
  assign retry_ok = retry_q < RETRY_MAX;

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fail     = 1'b0;
    code     = 3'd0;
    judge_ok = 1'b0;
    cap_err  = 1'b0;
    unique case (state)
      IDLE:
        if (start_go) state_nx = CLEAR;
      CLEAR:
        state_nx = ALIGN;
      ALIGN:
        if (bus.ALIGNED) begin
          state_nx = INIT;
        end else if (timer == ALIGN_LAST) begin
          fail = 1'b1;
          code = 3'd1;
        end
      INIT:
        state_nx = RUN;
      RUN:
        if (!bus.ALIGNED) begin
          fail    = 1'b1;
          code    = 3'd2;
          cap_err = 1'b1;
        end else if (timer == RUN_LAST) begin
          state_nx = DRAIN;
        end
      DRAIN:
        if (timer == 24'd1) state_nx = JUDGE;
      JUDGE: begin
        cap_err = 1'b1;
        if (bus.ERR_CNT <= THRESH) begin
          judge_ok = 1'b1;
          state_nx = DONE_ST;
        end else begin
          fail = 1'b1;
          code = 3'd3;
        end
      end
      DONE_ST:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
    // failure resolves to retry or final verdict in the same cycle
    if (fail)
      state_nx = retry_ok ? CLEAR : DONE_ST;
    if (abort_go)
      state_nx = IDLE;
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      timer <= 24'd0;
    end else if (state_nx != state) begin
      timer <= 24'd0;
    end else if (state == ALIGN ||
                 state == RUN ||
                 state == DRAIN) begin
      timer <= timer + 24'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      pass_q      <= 1'b0;
      fail_code_q <= 3'd0;
      retry_q     <= 4'd0;
      last_err_q  <= 8'd0;
    end else if (abort_go) begin
      pass_q      <= 1'b0;
      fail_code_q <= 3'd4;
    end else begin
      if (start_go) begin
        pass_q      <= 1'b0;
        fail_code_q <= 3'd0;
        retry_q     <= 4'd0;
      end
      if (cap_err)
        last_err_q <= bus.ERR_CNT;
      if (judge_ok) begin
        pass_q      <= 1'b1;
        fail_code_q <= 3'd0;
      end
      if (fail) begin
        fail_code_q <= code;
        if (retry_ok) retry_q <= retry_q + 4'd1;
        else          pass_q  <= 1'b0;
      end
    end
  end

  // strobes decode the upcoming state so they leave a flop
  always_comb begin
    rx_clr_nx    = (state_nx == CLEAR);
    align_req_nx = (state_nx == ALIGN);
    rx_init_nx   = (state_nx == INIT);
    tx_en_nx     = (state_nx == RUN);
    busy_nx      = (state_nx != IDLE);
    done_nx      = (state_nx == DONE_ST);
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      rx_clr_q    <= 1'b0;
      align_req_q <= 1'b0;
      rx_init_q   <= 1'b0;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rx_clr_q    <= rx_clr_nx;
      align_req_q <= align_req_nx;
      rx_init_q   <= rx_init_nx;
      tx_en_q     <= tx_en_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
    end
  end

  assign bus.RX_CLR    = rx_clr_q;
  assign bus.ALIGN_REQ = align_req_q;
  assign bus.RX_INIT   = rx_init_q;
  assign bus.TX_EN     = tx_en_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL_CODE = fail_code_q;
  assign bus.RETRY_CNT = retry_q;
  assign bus.LAST_ERR  = last_err_q;

endmodule

// File: tb/tb_parallel_test_ctrl.sv
// tb_parallel_test_ctrl: directed and random test sequences
// against an attempt-level outcome model.
module tb_parallel_test_ctrl;
  localparam int TC = 16;
  localparam int AT = 8;
  localparam int MR = 2;
  localparam int TH = 4;
  localparam int NONE = 99;

  logic CLK;
  logic RSTX;

  parallel_test_ctrl_if bus ();

  parallel_test_ctrl #(
    .TEST_CYCLES  (TC),
    .ALIGN_TIMEOUT(AT),
    .MAX_RETRY    (MR),
    .ERR_THRESH   (TH)
  ) dut (
    .CLK (CLK),
    .RSTX(RSTX),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int pd[3];
  int pl[3];
  int pe[3];
  int exp_last = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d",
               tag, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.RX_CLR, bus.RX_INIT,
                 bus.ALIGN_REQ, bus.TX_EN,
                 bus.BUSY, bus.DONE, bus.PASS,
                 bus.FAIL_CODE, bus.RETRY_CNT,
                 bus.LAST_ERR});
  endfunction

  // plan per attempt: align delay, RUN loss cycle, error count
  task automatic plan(input int a, input int d,
                      input int l, input int e);
    pd[a] = d;
    pl[a] = l;
    pe[a] = e;
  endtask

  task automatic plan_all(input int d,
                          input int l,
                          input int e);
    for (int a = 0; a <= MR; a++) plan(a, d, l, e);
  endtask

  task automatic run_seq(input string nm,
                         input bit spur);
    int e_cyc, e_att, e_pass, e_code;
    int e_align, e_tx;
    int cyc, att, ac, rc, ai;
    int n_clr, n_align, n_tx, n_busy, done_cyc;
    e_cyc = 0; e_att = 0; e_pass = 0;
    e_code = 0; e_align = 0; e_tx = 0;
    for (int a = 0; a <= MR; a++) begin
      e_att++;
      e_cyc++;
      if (pd[a] >= AT) begin
        e_align += AT;
        e_cyc   += AT;
        e_code   = 1;
      end else begin
        e_align += pd[a] + 1;
        e_cyc   += pd[a] + 2;
        if (pl[a] < TC) begin
          e_tx    += pl[a] + 1;
          e_cyc   += pl[a] + 1;
          e_code   = 2;
          exp_last = pe[a];
        end else begin
          e_tx    += TC;
          e_cyc   += TC + 3;
          exp_last = pe[a];
          if (pe[a] <= TH) begin
            e_pass = 1;
            e_code = 0;
            break;
          end
          e_code = 3;
        end
      end
    end

    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    cyc = 1; att = -1; ac = 0; rc = 0;
    n_clr = 0; n_align = 0; n_tx = 0;
    n_busy = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 1000) begin
      bus.START = (spur && cyc == 12);
      if (bus.BUSY) n_busy++;
      if (bus.RX_CLR) begin
        n_clr++;
        if (att < MR) att++;
        ac = 0;
        rc = 0;
        bus.ERR_CNT = 8'(pe[att]);
      end
      ai = (att < 0) ? 0 : att;
      if (bus.ALIGN_REQ) begin
        n_align++;
        bus.ALIGNED = (ac >= pd[ai]);
        ac++;
      end else if (bus.TX_EN) begin
        n_tx++;
        bus.ALIGNED = (rc != pl[ai]);
        rc++;
      end else begin
        bus.ALIGNED = 1'b1;
      end
      if (bus.DONE) done_cyc = cyc;
      @(negedge CLK);
      cyc++;
    end
    bus.START = 1'b0;

    chk({nm, "_done_cyc"}, done_cyc, e_cyc + 1);
    chk({nm, "_clr"}, n_clr, e_att);
    chk({nm, "_align"}, n_align, e_align);
    chk({nm, "_tx"}, n_tx, e_tx);
    chk({nm, "_busy"}, n_busy, e_cyc + 1);
    chk({nm, "_pass"}, int'(bus.PASS), e_pass);
    chk({nm, "_code"}, int'(bus.FAIL_CODE), e_code);
    chk({nm, "_retry"}, int'(bus.RETRY_CNT), e_att - 1);
    chk({nm, "_last"}, int'(bus.LAST_ERR), exp_last);
    chk({nm, "_done_end"}, int'(bus.DONE), 0);
    chk({nm, "_busy_end"}, int'(bus.BUSY), 0);
  endtask

  task automatic start_to_run(input int extra);
    int n;
    bus.ALIGNED = 1'b1;
    bus.ERR_CNT = 8'd0;
    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    n = 0;
    while (!bus.TX_EN && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_run", int'(bus.TX_EN), 1);
    repeat (extra) @(negedge CLK);
  endtask

  task automatic abort_test();
    int dn, bz;
    start_to_run(3);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    chk("busy_start_ign", int'(bus.TX_EN), 1);
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    chk("abort_busy", int'(bus.BUSY), 0);
    chk("abort_tx", int'(bus.TX_EN), 0);
    chk("abort_code", int'(bus.FAIL_CODE), 4);
    chk("abort_pass", int'(bus.PASS), 0);
    dn = 0;
    bz = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.DONE) dn++;
      if (bus.BUSY) bz++;
    end
    chk("abort_nodone", dn, 0);
    chk("abort_idle", bz, 0);
    bus.START = 1'b1;
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    @(negedge CLK);
    chk("start_w_abort", int'(bus.BUSY), 0);
  endtask

  task automatic reset_test();
    start_to_run(5);
    #2 RSTX = 1'b0;
    #1 chk("rst_mid_outs", outs(), 0);
    @(negedge CLK);
    @(negedge CLK);
    RSTX = 1'b1;
    exp_last = 0;
    chk("rst_mid_hold", outs(), 0);
  endtask

  initial begin
    RSTX        = 1'b1;
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    bus.ALIGNED = 1'b0;
    bus.ERR_CNT = 8'd0;
    #2 RSTX = 1'b0;
    #3 chk("rst_outs", outs(), 0);
    repeat (2) @(negedge CLK);
    RSTX = 1'b1;

    plan_all(0, NONE, 0);
    run_seq("clean", 1'b0);

    @(negedge CLK);
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.ABORT = 1'b0;
    chk("idle_abort_pass", int'(bus.PASS), 1);
    chk("idle_abort_code", int'(bus.FAIL_CODE), 0);

    plan_all(NONE, NONE, 0);
    run_seq("tmo", 1'b0);

    plan(0, 0, NONE, 5);
    plan(1, 0, NONE, 3);
    plan(2, 0, NONE, 0);
    run_seq("thresh", 1'b0);

    plan(0, 0, 5, 7);
    plan(1, 0, NONE, 0);
    plan(2, 0, NONE, 0);
    run_seq("lost", 1'b0);

    plan(0, 7, TC - 1, 9);
    plan(1, 7, NONE, TH);
    plan(2, 0, NONE, 0);
    run_seq("edge", 1'b1);

    abort_test();
    reset_test();
    plan_all(0, NONE, 0);
    run_seq("post_rst", 1'b0);

    for (int s = 0; s < 12; s++) begin
      for (int a = 0; a <= MR; a++) begin
        pd[a] = ($urandom_range(0, 3) == 0) ?
                int'($urandom_range(AT, AT + 4)) :
                int'($urandom_range(0, AT - 1));
        pl[a] = ($urandom_range(0, 3) == 0) ?
                int'($urandom_range(0, TC - 1)) :
                NONE;
        pe[a] = ($urandom_range(0, 3) == 0) ?
                int'($urandom_range(TH + 1, 255)) :
                int'($urandom_range(0, TH));
      end
      run_seq($sformatf("rnd%0d", s),
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
